// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two
// 16-bit SRAM phases, with freeze holding the pipeline until ready.
module sram_mem_ctrl #(
  parameter int ADDRESS_LEN = 32,
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_read,
  input  logic                   MEM_write,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [ADDRESS_LEN-1:0] ST_value,
  output logic [ADDRESS_LEN-1:0] MEM_out,
  output logic                   ready,
  output logic                   freeze,
  output logic [SRAM_AW-1:0]     SRAM_ADDR,
  output logic [15:0]            SRAM_DQ_out,
  input  logic [15:0]            SRAM_DQ_in,
  output logic                   SRAM_DQ_oe,
  output logic                   SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam int WW = SRAM_AW - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]          cnt, cnt_n;
  logic [WW-1:0]          word, word_n;
  logic [ADDRESS_LEN-1:0] data, data_n;
  logic [ADDRESS_LEN-1:0] out_n;
  logic                   ready_n;
  logic [SRAM_AW-1:0]     addr_n;
  logic [15:0]            dq_n;
  logic                   oe_n;
  logic                   we_n_n;

  logic [ADDRESS_LEN-1:0] offs;
  logic [WW-1:0]          widx;
  logic                   last;

  // Offset wraps modulo 2^ADDRESS_LEN; byte lane bits are dropped.
  assign offs = address - ADDRESS_LEN'(BASE_ADDR);
  assign widx = offs[WW+1:2];
  assign last = (cnt == LAST);

  logic unused_offs;
  assign unused_offs = ^{offs[ADDRESS_LEN-1:WW+2], offs[1:0]};

  assign freeze = (MEM_read | MEM_write) & ~ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    data_n  = data;
    out_n   = MEM_out;
    ready_n = 1'b0;
    addr_n  = SRAM_ADDR;
    dq_n    = SRAM_DQ_out;
    oe_n    = 1'b0;
    we_n_n  = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (MEM_write) begin
          word_n  = widx;
          data_n  = ST_value;
          addr_n  = {widx, 1'b0};
          dq_n    = ST_value[15:0];
          oe_n    = 1'b1;
          we_n_n  = 1'b0;
          state_n = WR_LO;
        end else if (MEM_read) begin
          word_n  = widx;
          addr_n  = {widx, 1'b0};
          state_n = RD_LO;
        end
      end
      RD_LO: begin
        if (last) begin
          out_n[15:0] = SRAM_DQ_in;
          cnt_n       = '0;
          addr_n      = {word, 1'b1};
          state_n     = RD_HI;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RD_HI: begin
        if (last) begin
          out_n[31:16] = SRAM_DQ_in;
          cnt_n        = '0;
          ready_n      = 1'b1;
          state_n      = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WR_LO: begin
        oe_n   = 1'b1;
        we_n_n = 1'b0;
        if (last) begin
          cnt_n   = '0;
          addr_n  = {word, 1'b1};
          dq_n    = data[31:16];
          state_n = WR_HI;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WR_HI: begin
        if (last) begin
          cnt_n   = '0;
          ready_n = 1'b1;
          state_n = DONE;
        end else begin
          oe_n   = 1'b1;
          we_n_n = 1'b0;
          cnt_n  = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word        <= '0;
      data        <= '0;
      MEM_out     <= '0;
      ready       <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      word        <= word_n;
      data        <= data_n;
      MEM_out     <= out_n;
      ready       <= ready_n;
      SRAM_ADDR   <= addr_n;
      SRAM_DQ_out <= dq_n;
      SRAM_DQ_oe  <= oe_n;
      SRAM_WE_N   <= we_n_n;
    end
  end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- MEM-stage data-memory controller for the 5-stage pipeline.
- Turns one 32-bit load/store from the MEM stage into two sequential 16-bit accesses on an off-chip SRAM.
- Produces the `freeze` signal that the inter-stage layer registers consume, holding the whole pipeline until the access completes.
- Returns load data to the MEM/WB register.

Parameters:
- ADDRESS_LEN, 32, width of CPU address and data.
- SRAM_AW, 18, SRAM halfword address width.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 3, cycles each SRAM halfword phase is held (legal range ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_read  in  1  MEM-stage load request.
- MEM_write  in  1  MEM-stage store request.
- address  in  ADDRESS_LEN  byte address (ALU result).
- ST_value  in  ADDRESS_LEN  store data.
- MEM_out  out  ADDRESS_LEN  load data, registered.
- ready  out  1  one-cycle completion pulse.
- freeze  out  1  pipeline hold = (MEM_read|MEM_write) & ~ready, combinational.
- SRAM_ADDR  out  SRAM_AW  SRAM halfword address.
- SRAM_DQ_out  out  16  write data to SRAM.
- SRAM_DQ_in  in  16  read data from SRAM.
- SRAM_DQ_oe  out  1  1 = controller drives DQ; top level builds the tristate.
- SRAM_WE_N  out  1  SRAM write enable, active low.

Behaviour:
- Reset: one clock with rst=1 forces:
  - state=IDLE, counter=0;
  - MEM_out=0, ready=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1;
  - latched address and data cleared.
  - Reset overrides any in-flight access; the aborted access is not completed or retried by the controller.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - If MEM_write, latch word index W=(address-BASE_ADDR)>>2 and ST_value; go to WR_LO.
  - Else if MEM_read, latch W; go to RD_LO.
  - Write has priority when both are asserted.
  - Address bits [1:0] are ignored. Subtraction wraps modulo 2^ADDRESS_LEN; the result is truncated to SRAM_AW-1 bits.
- Phase states: each lasts exactly WAIT_CYCLES cycles, counted by counter 0..WAIT_CYCLES-1.
  - On counter==WAIT_CYCLES-1, advance and clear the counter.
  - SRAM_ADDR is {W,0} in *_LO states and {W,1} in *_HI states.
  - SRAM_ADDR is driven registered-stable for the whole phase.
- RD_LO / RD_HI:
  - SRAM_WE_N=1, SRAM_DQ_oe=0.
  - On the last phase cycle, sample SRAM_DQ_in into MEM_out[15:0] (LO) or MEM_out[31:16] (HI).
  - RD_LO→RD_HI→DONE.
- WR_LO / WR_HI:
  - SRAM_WE_N=0, SRAM_DQ_oe=1 for every phase cycle.
  - SRAM_DQ_out=data[15:0] (LO) or data[31:16] (HI).
  - WR_LO→WR_HI→DONE.
- DONE:
  - ready=1 for exactly this one cycle; SRAM_WE_N=1, SRAM_DQ_oe=0.
  - Unconditional transition to IDLE.
  - MEM_out keeps the last load value until the next load's LO sample; it is unchanged by stores.
- Latency:
  - A request first seen in IDLE at cycle 0 gives ready at cycle 2*WAIT_CYCLES+1.
  - freeze is high for cycles 0..2*WAIT_CYCLES (2*WAIT_CYCLES+1 cycles) and low in the ready cycle, so the layer registers advance on that edge.
- Back-to-back requests: the next request is seen in IDLE the cycle after DONE; there is no extra bubble beyond that IDLE cycle.
- Request dropped mid-transaction (e.g. a flush): the access still runs to DONE and ready still pulses. freeze falls as soon as the request is deasserted.
- No request: the controller stays in IDLE with freeze=0 and ready=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with MEM_read=1 → ready=0, SRAM_WE_N=1, SRAM_DQ_oe=0, MEM_out=0. freeze=1 (request present, not ready).
- Store (WAIT_CYCLES=3):
  - Stimulus: MEM_write=1, address=1024, ST_value=0xDEADBEEF.
  - SRAM_ADDR=0 with DQ_out=0xBEEF in cycles 1–3; SRAM_ADDR=1 with DQ_out=0xDEAD in cycles 4–6.
  - SRAM_WE_N=0 in cycles 1–6; ready=1 only in cycle 7; freeze=1 in cycles 0–6.
- Load from the behavioural SRAM model after the store:
  - Stimulus: MEM_read=1, address=1024.
  - MEM_out=0xDEADBEEF in the ready cycle (cycle 7); SRAM_DQ_oe=0 throughout.
- Address mapping: store 0x12345678 to address 1032 → SRAM halfword 4=0x5678, halfword 5=0x1234. address=1035 gives the same halfwords.
- Back-to-back: load immediately followed by a store, each with a request held until its own ready.
  - First ready at cycle 7; second request seen in IDLE at cycle 8; second ready at cycle 15.
  - MEM_out unchanged by the store.
- Reset mid-load: rst at cycle 3 of a load with MEM_read held → controller returns to IDLE, then restarts. ready occurs 7 cycles after rst falls, with correct data.
- WAIT_CYCLES=1 build: a load is seen at cycle 0 and ready=1 at cycle 3.
